stats_collector: RTL and testbench
==================================

Name: stats_collector

Overview:
- Receiving end of the stats stream emitted by stats_packer_avlstrm instances.
- Consumes stats packets (one stats_t {addr, val} per flit, sop..eop) and decodes each addr into a local register window.
- Commits each packet atomically into a host-readable register file, so the host never sees a half-updated snapshot from one producer.
- Sits next to the CSR/MMIO block; one instance per stats ring.

Parameters:
- DATA_W, 512, width of in_data; the stats_t occupies in_data[63:0].
- BASE_ADDR, 32'h0000_0000, first stats address owned by this collector.
- NUM_REGS, 16, number of 32-bit stats registers, power of 2, 2..64.
- AW, $clog2(NUM_REGS), host read index width.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  synchronous active-low reset
- in_valid  in  1  stream flit valid
- in_sop  in  1  first flit of stats packet
- in_eop  in  1  last flit of stats packet
- in_data  in  DATA_W  flit; [63:32]=addr, [31:0]=val
- in_empty  in  $clog2(DATA_W/8)  ignored
- in_ready  out  1  stream ready
- in_almost_full  out  1  tied 0
- rd_en  in  1  host read strobe
- rd_addr  in  AW  register index
- rd_valid  out  1  read data valid
- rd_data  out  32  read data
- pkt_cnt  out  32  committed packets
- err_cnt  out  32  framing errors
- oor_cnt  out  32  out-of-range addr flits

Behaviour:
- Reset (Rst_n=0 sampled at posedge):
  - staging, active, dirty bits, all counters, rd_valid and rd_data clear to 0; FSM goes to IDLE.
  - in_ready is 0 while Rst_n=0 and 1 from the first cycle after reset deasserts.
  - Reset mid-packet discards the packet with no error count.
- Accept rule: a flit is accepted when in_valid & in_ready. in_ready is 1 in every state.
- Address decode: idx = addr - BASE_ADDR (32-bit).
  - In range when addr >= BASE_ADDR and idx < NUM_REGS.
  - Out-of-range flits are not written; oor_cnt increments; packet framing proceeds normally.
- FSM states: IDLE, COLLECT, DROP.
  - IDLE, accepted sop&eop: write staging[idx], commit the same cycle, stay IDLE.
  - IDLE, accepted sop&!eop: write staging[idx], go to COLLECT.
  - IDLE, accepted !sop: framing error; err_cnt++. Go to DROP if !eop, otherwise stay IDLE. No write.
  - COLLECT, accepted !sop: write staging[idx]. If eop, commit and go to IDLE.
  - COLLECT, accepted sop: missing eop. err_cnt++, clear all dirty bits (discard the partial packet), then treat the flit as a new sop in IDLE semantics during the same cycle.
  - DROP: discard flits until an accepted eop, then go to IDLE. An accepted sop in DROP restarts as in IDLE (no extra err_cnt).
- Staging write: staging[idx] <= val; dirty[idx] <= 1. A repeated idx within one packet keeps the last value.
- Commit (on the eop cycle, including the eop flit's own write):
  - every dirty entry copies to active, with the eop flit's value forwarded so it is not lost;
  - dirty clears;
  - pkt_cnt++ (only on commit, not on discard).
- Host read: 1-cycle latency. rd_valid(t+1)=rd_en(t); rd_data(t+1)=active[rd_addr(t)].
  - A read in the same cycle as a commit returns the pre-commit value.
  - rd_data holds its value when rd_en=0.
- Counters are 32-bit and wrap at 2^32-1 to 0. A single flit may increment oor_cnt and err_cnt in the same cycle.

Test Plan:
- BASE_ADDR=0x100. Packet of 3 flits {0x100,0xA},{0x101,0xB},{0x105,0xC} -> after the eop cycle, reads of idx 0/1/5 return 0xA/0xB/0xC one cycle after rd_en; pkt_cnt=1; other indices read 0.
- Same as above, but read idx 1 on the cycle between flits 2 and 3 -> returns 0 (uncommitted); the read on the cycle after eop returns 0xB.
- Flit without sop in IDLE, eop=0, then 2 more flits ending in eop -> err_cnt=1, no register changes, pkt_cnt unchanged; the next valid packet commits normally.
- Packet {0x100,1}, then sop {0x102,2} with eop -> err_cnt=1; idx0 reads 0, idx2 reads 2; pkt_cnt=1.
- Flit addr 0x0FF and a flit with addr 0x100+NUM_REGS inside a valid packet -> oor_cnt=2; the in-range flits of the packet still commit.
- Preload err_cnt to 0xFFFF_FFFF via forced stimulus, inject an error -> err_cnt=0. Assert Rst_n=0 mid-packet -> all reads return 0 and counters are 0 after reset.

Source files
------------

// File: rtl/stats_collector.sv
// Stats stream sink: decodes {addr,val} flits into a staging window and commits
// each packet atomically into the host-readable active register file.
module stats_collector #(
  parameter int          DATA_W    = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          AW        = $clog2(NUM_REGS)
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        in_valid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W/8)-1:0] in_empty,
  output logic                        in_ready,
  output logic                        in_almost_full,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  output logic                        rd_valid,
  output logic [31:0]                 rd_data,
  output logic [31:0]                 pkt_cnt,
  output logic [31:0]                 err_cnt,
  output logic [31:0]                 oor_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

  state_t                 state, state_n;
  logic [31:0]            staging [NUM_REGS];
  logic [31:0]            active  [NUM_REGS];
  logic [NUM_REGS-1:0]    dirty;

  logic                   acc, new_pkt, wr, commit, err, clr;
  logic [31:0]            addr, val, idx32;
  logic                   in_range, wr_en, oor;
  logic [AW-1:0]          idx;
  logic                   unused_bits;

  assign in_almost_full = 1'b0;
  assign unused_bits    = ^{in_empty, in_data[DATA_W-1:64]};

  assign acc      = in_valid & in_ready;
  assign addr     = in_data[63:32];
  assign val      = in_data[31:0];
  assign idx32    = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && (idx32 < 32'(NUM_REGS));
  assign idx      = idx32[AW-1:0];
  assign wr_en    = wr & in_range;
  assign oor      = wr & ~in_range;

  always_comb begin
    state_n = state;
    new_pkt = 1'b0;
    wr      = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    clr     = 1'b0;
    if (acc) begin
      unique case (state)
        COLLECT: begin
          if (in_sop) begin
            // missing eop: drop the partial packet, restart on this flit
            err = 1'b1; clr = 1'b1; new_pkt = 1'b1;
          end else begin
            wr = 1'b1;
            if (in_eop) begin commit = 1'b1; state_n = IDLE; end
          end
        end
        DROP: begin
          if (in_sop)      new_pkt = 1'b1;
          else if (in_eop) state_n = IDLE;
        end
        default: begin
          if (in_sop) new_pkt = 1'b1;
          else begin
            err     = 1'b1;
            state_n = in_eop ? IDLE : DROP;
          end
        end
      endcase
      if (new_pkt) begin
        wr      = 1'b1;
        commit  = in_eop;
        state_n = in_eop ? IDLE : COLLECT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      dirty    <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      oor_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        staging[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      state    <= state_n;
      in_ready <= 1'b1;
      pkt_cnt  <= pkt_cnt + 32'(commit);
      err_cnt  <= err_cnt + 32'(err);
      oor_cnt  <= oor_cnt + 32'(oor);
      rd_valid <= rd_en;
      // active is read before this edge's commit lands, giving pre-commit data
      if (rd_en) rd_data <= active[rd_addr];
      for (int i = 0; i < NUM_REGS; i++) begin
        logic hit;
        hit = wr_en && (idx == AW'(i));
        if (hit) staging[i] <= val;
        if (commit)   dirty[i] <= 1'b0;
        else if (clr) dirty[i] <= hit;
        else if (hit) dirty[i] <= 1'b1;
        // the eop flit's own value is forwarded since staging updates this edge
        if (commit && (hit || (dirty[i] && !clr)))
          active[i] <= hit ? val : staging[i];
      end
    end
  end

endmodule

// File: tb/tb_stats_collector.sv
// Directed bench for stats_collector: read responses checked through a
// scoreboard queue, counters checked directly against hand-computed values.
module tb_stats_collector;
  localparam int DATA_W = 512;
  localparam int NUM_REGS = 16;
  localparam int AW = $clog2(NUM_REGS);

  logic                        Clk = 1'b0;
  logic                        Rst_n;
  logic                        in_valid, in_sop, in_eop;
  logic [DATA_W-1:0]           in_data;
  logic [$clog2(DATA_W/8)-1:0] in_empty;
  logic                        in_ready, in_almost_full;
  logic                        rd_en;
  logic [AW-1:0]               rd_addr;
  logic                        rd_valid;
  logic [31:0]                 rd_data, pkt_cnt, err_cnt, oor_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  stats_collector #(.DATA_W(DATA_W), .BASE_ADDR(32'h100), .NUM_REGS(NUM_REGS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
    .in_almost_full(in_almost_full), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .oor_cnt(oor_cnt));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every rd_valid pops one expected value
  always @(negedge Clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic flit(input logic sop, input logic eop, input logic [31:0] a, input logic [31:0] v);
    in_valid = 1'b1; in_sop = sop; in_eop = eop;
    in_data = '0; in_data[63:32] = a; in_data[31:0] = v;
    @(negedge Clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic rd(input int i, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = AW'(i); exp_q.push_back(exp);
    @(negedge Clk);
    rd_en = 1'b0;
  endtask

  task automatic cnts(input string tag, input logic [31:0] p, input logic [31:0] e, input logic [31:0] o);
    chk({tag, "_pkt"}, pkt_cnt, p);
    chk({tag, "_err"}, err_cnt, e);
    chk({tag, "_oor"}, oor_cnt, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    cnts("rst", 0, 0, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // basic 3-flit packet
    flit(1, 0, 32'h100, 32'hA);
    flit(0, 0, 32'h101, 32'hB);
    flit(0, 1, 32'h105, 32'hC);
    cnts("t1", 1, 0, 0);
    rd(0, 32'hA); rd(1, 32'hB); rd(5, 32'hC); rd(2, 0); rd(15, 0);

    // mid-packet read sees the old committed value
    flit(1, 0, 32'h100, 32'h11);
    flit(0, 0, 32'h101, 32'h22);
    rd(1, 32'hB);
    flit(0, 1, 32'h106, 32'h33);
    rd(1, 32'h22); rd(0, 32'h11); rd(6, 32'h33); rd(5, 32'hC);
    cnts("t2", 2, 0, 0);

    // flit without sop in IDLE -> drop until eop
    flit(0, 0, 32'h102, 32'h55);
    flit(0, 0, 32'h103, 32'h66);
    flit(0, 1, 32'h104, 32'h77);
    cnts("t3", 2, 1, 0);
    rd(2, 0); rd(3, 0); rd(4, 0);
    flit(1, 1, 32'h102, 32'h99);
    chk("t3_next_pkt", pkt_cnt, 3);
    rd(2, 32'h99);

    // missing eop: partial discarded, new sop packet commits
    flit(1, 0, 32'h107, 32'h1);
    flit(1, 1, 32'h102, 32'h2);
    cnts("t4", 4, 2, 0);
    rd(7, 0); rd(2, 32'h2);

    // out-of-range flits below and above the window
    flit(1, 0, 32'h0FF, 32'hDEAD);
    flit(0, 0, 32'h108, 32'h88);
    flit(0, 0, 32'h110, 32'hBEEF);
    flit(0, 1, 32'h109, 32'h99);
    cnts("t5", 5, 2, 2);
    rd(8, 32'h88); rd(9, 32'h99); rd(0, 32'h11); rd(15, 0);

    // repeated index keeps last value
    flit(1, 0, 32'h10A, 32'h1);
    flit(0, 1, 32'h10A, 32'h2);
    rd(10, 32'h2);

    // read on the commit cycle returns the pre-commit value
    rd_en = 1'b1; rd_addr = AW'(10); exp_q.push_back(32'h2);
    flit(1, 1, 32'h10A, 32'h3);
    rd_en = 1'b0;
    rd(10, 32'h3);
    chk("t6_pkt", pkt_cnt, 7);

    // err_cnt wrap
    force dut.err_cnt = 32'hFFFF_FFFF;
    #1 release dut.err_cnt;
    flit(0, 1, 32'h100, 32'h0);
    chk("err_wrap", err_cnt, 0);
    rd(0, 32'h11);

    // reset mid-packet
    flit(1, 0, 32'h100, 32'h5A);
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    cnts("t7_rst", 0, 0, 0);
    rd(0, 0); rd(2, 0); rd(8, 0); rd(10, 0);
    flit(1, 1, 32'h103, 32'h7);
    cnts("t7_post", 1, 0, 0);
    rd(3, 32'h7);

    repeat (3) @(negedge Clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
